bit_align_multi: RTL and testbench
==================================

# bit_align_multi

Multi-lane, parametrised successor to the single-lane LVDS bit aligner. It sits between the deserialiser master/slave capture paths and the IDELAY tap inputs. All lanes sweep the full delay range in parallel, with a programmable settle and sample window per tap. Each lane then sets its delay to the centre of its widest contiguous passing-tap window and raises a per-lane fail flag if that eye is too narrow.

## Interface
- DATA_WIDTH, 10, deserialised word width per lane
- NUM_LANES, 4, number of lanes aligned in parallel
- TAP_NUMS, 32, delay taps swept (2..2^TAP_W)
- TAP_W, 5, tap value width
- SETTLE_CYCLES, 4, cycles waited after each tap change before sampling (>=2)
- SAMPLE_CYCLES, 16, cycles of match evaluation per tap (>=1)
- MIN_EYE, 3, minimum passing-window width for a lane to pass
- clk  in  1  single clock for all logic
- reset_n  in  1  reset, synchronous, active-low
- enable  in  1  high starts/holds alignment; low aborts to IDLE
- idelayCtrl_rdy  in  1  IDELAYCTRL ready; sweep starts only when high
- master_data  in  NUM_LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- slave_data  in  NUM_LANES*DATA_WIDTH  inverted-polarity capture, same packing
- tap_value  out  NUM_LANES*TAP_W  per-lane delay tap, lane i at [i*TAP_W +: TAP_W]
- lane_fail  out  NUM_LANES  lane best window < MIN_EYE
- bit_align_done  out  1  alignment complete, taps final

## Operation
- Per-lane match is registered: match[i] <= (master_i == ~slave_i).
- FSM states: IDLE, SETTLE, SAMPLE, NEXT, CENTER, DONE.
- IDLE: scan_tap = 0 and all outputs are 0. When enable && idelayCtrl_rdy, clear the per-lane trackers and go to SETTLE.
- SETTLE: all tap_value lanes equal scan_tap. Wait SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: runs for SAMPLE_CYCLES cycles. good[i] starts at 1 and is ANDed with match[i] every cycle, so a single mismatch marks the tap bad.
- NEXT: one cycle. Per lane:
  - If good: cur_len++. When cur_len was 0, cur_start = scan_tap.
  - If bad: cur_len = 0.
  - Then, if the updated cur_len > best_len (strictly), best_start = cur_start and best_len = cur_len.
  - After this, if scan_tap == TAP_NUMS-1 go to CENTER; otherwise scan_tap++ and go to SETTLE.
- CENTER: one cycle. Per lane:
  - Passing lane: tap = best_start + ((best_len-1)>>1), with arithmetic in TAP_W+1 bits, truncated to TAP_W.
  - If best_len < MIN_EYE: lane_fail[i] = 1 and tap = 0.
  - Go to DONE.
- DONE: bit_align_done = 1 and the taps are held. Leave DONE only on enable low or reset.
- enable low in any non-IDLE state: next cycle go to IDLE, tap_value = 0, lane_fail = 0, done = 0.
- idelayCtrl_rdy low during a sweep: the FSM freezes in its current state and counters hold.
- Ties: the earliest (lowest best_start) window wins. A window ending at tap TAP_NUMS-1 is counted.

## Timing
- Reset (reset_n low at an edge): next cycle all outputs = 0, FSM in IDLE, all counters and trackers cleared. This also applies mid-sweep.
- Per tap: SETTLE_CYCLES + SAMPLE_CYCLES + 1 cycles. With defaults this is 21 cycles per tap and 672 for the full sweep.
- Enable is sampled in IDLE at cycle 0. The first SETTLE is cycle 1. CENTER is at cycle 1 + TAP_NUMS*(S+P+1). bit_align_done rises one cycle after CENTER, so final taps are stable at least one cycle before done.
- tap_value changes only on entry to SETTLE (step of +1) and at CENTER.

## Configuration
- BIT_ALIGN_MONITOR_EN defined:
  - In DONE, each lane counts consecutive cycles with match low, saturating at 8. The count resets on any match high.
  - If any non-failed lane reaches 8: done drops next cycle, trackers clear, scan_tap = 0, and the FSM goes to SETTLE for an automatic re-sweep.
- Not defined: DONE holds unconditionally and no monitor logic is present.

## Test plan
- All lanes slave = ~master at every tap, defaults -> every lane tap 15, lane_fail = 0, done at cycle 674.
- Lane 0 passes only taps 8..20, others pass all -> lane 0 tap 14, others 15, lane_fail = 0.
- Lane 1 windows at taps 2..5 and 10..19 -> tap 14.
- Lane 1 tie windows at taps 2..5 and 10..13 -> tap 3.
- Lane 2 passes only taps 6..7 (MIN_EYE = 3) -> lane_fail = 4'b0100, lane 2 tap 0, done still asserts.
- Lane 3 has a one-cycle mismatch inside the SAMPLE window at tap 16 only, otherwise passes all -> windows 0..15 and 17..31 -> tap 7.
- enable low at cycle 300 -> IDLE next cycle, all outputs 0. Re-raise -> full sweep with identical results. reset_n low mid-sweep -> all outputs 0 next cycle.
- With BIT_ALIGN_MONITOR_EN, after done force lane 0 mismatch for 8 cycles -> done falls, re-sweep starts from tap 0, done reasserts 673 cycles later.

Source files
------------

// File: rtl/bit_align_multi.sv
// Multi-lane IDELAY bit aligner: sweeps all taps and centres each lane in its widest passing window.
// Optional post-alignment link monitor with automatic re-sweep: define BIT_ALIGN_MONITOR_EN.
module bit_align_multi #(
  parameter int DATA_WIDTH    = 10,
  parameter int NUM_LANES     = 4,
  parameter int TAP_NUMS      = 32,
  parameter int TAP_W         = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_EYE       = 3
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            idelayCtrl_rdy,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] master_data,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] slave_data,
  output logic [NUM_LANES*TAP_W-1:0]      tap_value,
  output logic [NUM_LANES-1:0]            lane_fail,
  output logic                            bit_align_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] SAMPLE = 3'd2;
  localparam logic [2:0] NEXT   = 3'd3;
  localparam logic [2:0] CENTER = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int LEN_W   = TAP_W + 1;

  logic [2:0]                            state_q, state_d;
  logic [TAP_W-1:0]                      scan_q, scan_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [NUM_LANES-1:0]                  match_q, match_d;
  logic [NUM_LANES-1:0]                  good_q, good_d;
  logic [NUM_LANES-1:0][LEN_W-1:0]       cur_len_q, cur_len_d, best_len_q, best_len_d;
  logic [NUM_LANES-1:0][TAP_W-1:0]       cur_start_q, cur_start_d, best_start_q, best_start_d;
  logic [NUM_LANES-1:0][TAP_W-1:0]       tap_q, tap_d;
  logic [NUM_LANES-1:0]                  fail_q, fail_d;
  logic                                  done_q, done_d;
  logic                                  start_sweep;

  logic [NUM_LANES-1:0][LEN_W-1:0]       nx_cur_len, nx_best_len;
  logic [NUM_LANES-1:0][TAP_W-1:0]       nx_cur_start, nx_best_start, nx_tap;
  logic [NUM_LANES-1:0]                  nx_fail;

`ifdef BIT_ALIGN_MONITOR_EN
  logic [NUM_LANES-1:0][3:0]             mon_q, mon_d;
  logic                                  mon_trip;
`endif

  assign tap_value      = tap_q;
  assign lane_fail      = fail_q;
  assign bit_align_done = done_q;

  // Tracker update for the tap just sampled, plus the centre it would imply if it were the last tap.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      match_d[i]       = master_data[i*DATA_WIDTH +: DATA_WIDTH] == ~slave_data[i*DATA_WIDTH +: DATA_WIDTH];
      nx_cur_len[i]    = '0;
      nx_cur_start[i]  = cur_start_q[i];
      if (good_q[i]) begin
        nx_cur_len[i] = cur_len_q[i] + LEN_W'(1);
        if (cur_len_q[i] == '0) nx_cur_start[i] = scan_q;
      end
      nx_best_len[i]   = best_len_q[i];
      nx_best_start[i] = best_start_q[i];
      if (nx_cur_len[i] > best_len_q[i]) begin
        nx_best_len[i]   = nx_cur_len[i];
        nx_best_start[i] = nx_cur_start[i];
      end
      nx_fail[i] = nx_best_len[i] < LEN_W'(MIN_EYE);
      nx_tap[i]  = nx_fail[i] ? '0
                 : TAP_W'({1'b0, nx_best_start[i]} + ((nx_best_len[i] - LEN_W'(1)) >> 1));
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    cnt_d        = cnt_q;
    good_d       = good_q;
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    tap_d        = tap_q;
    fail_d       = fail_q;
    start_sweep  = 1'b0;
`ifdef BIT_ALIGN_MONITOR_EN
    mon_d        = '0;
    mon_trip     = 1'b0;
`endif
    if (state_q != IDLE && !enable) begin
      state_d      = IDLE;
      scan_d       = '0;
      cnt_d        = '0;
      good_d       = '0;
      cur_len_d    = '0;
      cur_start_d  = '0;
      best_len_d   = '0;
      best_start_d = '0;
      tap_d        = '0;
      fail_d       = '0;
    end else if (state_q != IDLE && !idelayCtrl_rdy) begin
`ifdef BIT_ALIGN_MONITOR_EN
      mon_d = mon_q;
`endif
    end else begin
      case (state_q)
        IDLE:   if (enable && idelayCtrl_rdy) start_sweep = 1'b1;
        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_d   = '0;
            good_d  = '1;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SAMPLE: begin
          good_d = good_q & match_q;
          if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = NEXT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        NEXT: begin
          cur_len_d    = nx_cur_len;
          cur_start_d  = nx_cur_start;
          best_len_d   = nx_best_len;
          best_start_d = nx_best_start;
          // Final taps are loaded on entry to CENTER so they settle a cycle ahead of done.
          if (scan_q == TAP_W'(TAP_NUMS - 1)) begin
            tap_d   = nx_tap;
            fail_d  = nx_fail;
            state_d = CENTER;
          end else begin
            scan_d  = scan_q + TAP_W'(1);
            tap_d   = {NUM_LANES{TAP_W'(scan_q + TAP_W'(1))}};
            state_d = SETTLE;
          end
        end
        CENTER: state_d = DONE;
        DONE: begin
`ifdef BIT_ALIGN_MONITOR_EN
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            mon_d[i] = match_q[i] ? 4'd0 : ((mon_q[i] == 4'd8) ? 4'd8 : mon_q[i] + 4'd1);
            if (mon_q[i] == 4'd8 && !fail_q[i]) mon_trip = 1'b1;
          end
          if (mon_trip) begin
            start_sweep = 1'b1;
            mon_d       = '0;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
      if (start_sweep) begin
        state_d      = SETTLE;
        scan_d       = '0;
        cnt_d        = '0;
        good_d       = '0;
        cur_len_d    = '0;
        cur_start_d  = '0;
        best_len_d   = '0;
        best_start_d = '0;
        tap_d        = '0;
        fail_d       = '0;
      end
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      scan_q       <= '0;
      cnt_q        <= '0;
      match_q      <= '0;
      good_q       <= '0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      tap_q        <= '0;
      fail_q       <= '0;
      done_q       <= 1'b0;
`ifdef BIT_ALIGN_MONITOR_EN
      mon_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      good_q       <= good_d;
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      tap_q        <= tap_d;
      fail_q       <= fail_d;
      done_q       <= done_d;
`ifdef BIT_ALIGN_MONITOR_EN
      mon_q        <= mon_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_align_multi.sv
// Randomized bench for bit_align_multi: a channel model turns per-lane pass masks into data,
// and a window-search reference model predicts the final taps and fail flags.
module tb_bit_align_multi;
  localparam int DW = 10, NL = 4, TN = 32, TW = 5, S = 4, P = 16, ME = 3;
  localparam int PER_TAP  = S + P + 1;
  localparam int DONE_CYC = 2 + TN * PER_TAP;

  logic             clk = 1'b0;
  logic             reset_n, enable, rdy;
  logic [NL*DW-1:0] master, slave;
  logic [NL*TW-1:0] tap;
  logic [NL-1:0]    fail;
  logic             done;

  logic [TN-1:0]    pass_m   [NL];
  logic [TN-1:0]    glitch_m [NL];
  logic [NL-1:0]    force_bad;
  int               age      [NL];
  logic [TW-1:0]    prev_tap [NL];
  int               n_cmp = 0, n_err = 0;

  bit_align_multi #(
    .DATA_WIDTH(DW), .NUM_LANES(NL), .TAP_NUMS(TN), .TAP_W(TW),
    .SETTLE_CYCLES(S), .SAMPLE_CYCLES(P), .MIN_EYE(ME)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .idelayCtrl_rdy(rdy),
    .master_data(master), .slave_data(slave),
    .tap_value(tap), .lane_fail(fail), .bit_align_done(done)
  );

  always #5 clk = ~clk;

  // Channel: a lane's capture matches when its current tap is in the pass mask;
  // a glitch tap gets one bad word in the middle of its dwell.
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      logic [TW-1:0] t;
      logic [DW-1:0] m;
      bit ok;
      t = tap[i*TW +: TW];
      if (t != prev_tap[i] || !enable) age[i] = 0; else age[i] = age[i] + 1;
      prev_tap[i] = t;
      m  = DW'($urandom);
      ok = pass_m[i][t] && !(glitch_m[i][t] && age[i] == 10) && !force_bad[i];
      master[i*DW +: DW] = m;
      slave[i*DW +: DW]  = ok ? ~m : (~m ^ (DW'(1) << $urandom_range(DW-1, 0)));
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input logic [TN-1:0] good, output int tp, output bit fl);
    int best_len, best_st, run;
    best_len = 0; best_st = 0; run = 0;
    for (int t = 0; t < TN; t++) begin
      if (good[t]) begin
        run++;
        if (run > best_len) begin best_len = run; best_st = t - run + 1; end
      end else begin
        run = 0;
      end
    end
    fl = (best_len < ME);
    tp = fl ? 0 : best_st + (best_len - 1) / 2;
  endtask

  task automatic run_sweep(input int stall);
    int n, tp;
    bit fl, seen;
    logic [NL*TW-1:0] expv, pre;
    logic [NL-1:0] expf;
    for (int i = 0; i < NL; i++) begin
      model(pass_m[i] & ~glitch_m[i], tp, fl);
      expv[i*TW +: TW] = TW'(tp);
      expf[i] = fl;
    end
    @(negedge clk); enable = 1'b1;
    seen = 0; pre = '0;
    for (n = 1; n <= DONE_CYC + stall + 50; n++) begin
      @(negedge clk);
      if (n == DONE_CYC + stall - 1) pre = tap;
      if (stall == 0 && n <= TN * PER_TAP && (n - 1) % PER_TAP == 0)
        check("sweep_tap", tap, {NL{TW'((n - 1) / PER_TAP)}});
      if (stall > 0 && n == 100) rdy = 1'b0;
      if (stall > 0 && n == 100 + stall) rdy = 1'b1;
      if (done) begin seen = 1; break; end
    end
    check("done_seen", seen, 1);
    check("done_cycle", n, DONE_CYC + stall);
    check("tap_pre_done", pre, expv);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("tap_l%0d", i), tap[i*TW +: TW], expv[i*TW +: TW]);
      check($sformatf("fail_l%0d", i), fail[i], expf[i]);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tap"}, tap, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic end_sweep();
    @(negedge clk); enable = 1'b0;
    @(negedge clk); check_zero("disable");
  endtask

  task automatic all_pass();
    for (int i = 0; i < NL; i++) begin pass_m[i] = '1; glitch_m[i] = '0; end
  endtask

  task automatic set_range(input int lane, input int lo, input int hi);
    for (int t = lo; t <= hi; t++) pass_m[lane][t] = 1'b1;
  endtask

  task automatic directed_b();
    all_pass();
    pass_m[0] = '0; set_range(0, 8, 20);
    pass_m[1] = '0; set_range(1, 2, 5); set_range(1, 10, 19);
    pass_m[2] = '0; set_range(2, 6, 7);
    glitch_m[3][16] = 1'b1;
  endtask

  initial begin
    rdy = 1'b1; enable = 1'b0; reset_n = 1'b0; force_bad = '0;
    for (int i = 0; i < NL; i++) begin age[i] = 0; prev_tap[i] = '0; end
    all_pass();
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); check_zero("reset");

    // all lanes pass everywhere
    run_sweep(0); end_sweep();
    // mixed windows, narrow eye, single-cycle glitch
    directed_b(); run_sweep(0); end_sweep();
    // tie between equal windows, with an IDELAYCTRL-not-ready stall mid-sweep
    all_pass(); pass_m[1] = '0; set_range(1, 2, 5); set_range(1, 10, 13);
    run_sweep(37); end_sweep();

    // abort by enable, then identical rerun
    directed_b();
    @(negedge clk); enable = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_pre_tap", tap, {NL{TW'(299 / PER_TAP)}});
    enable = 1'b0;
    @(negedge clk); check_zero("abort");
    run_sweep(0); end_sweep();

    // reset mid-sweep
    @(negedge clk); enable = 1'b1;
    repeat (200) @(negedge clk);
    check("rst_pre_tap", tap, {NL{TW'(199 / PER_TAP)}});
    reset_n = 1'b0; enable = 1'b0;
    @(negedge clk); check_zero("midreset");
    reset_n = 1'b1;

    // random pass masks
    repeat (5) begin
      for (int i = 0; i < NL; i++) begin
        int r, st, ln;
        r = $urandom_range(0, 3);
        if (r == 0) pass_m[i] = '1;
        else begin
          pass_m[i] = '0;
          repeat (r) begin
            st = $urandom_range(0, TN - 1);
            ln = $urandom_range(0, 12);
            for (int k = 0; k < ln; k++) if (st + k < TN) pass_m[i][st + k] = 1'b1;
          end
        end
        glitch_m[i] = ($urandom_range(0, 2) == 0) ? (TN'(1) << $urandom_range(0, TN - 1)) : '0;
      end
      run_sweep(0); end_sweep();
    end

`ifdef BIT_ALIGN_MONITOR_EN
    begin
      int k;
      bit dropped;
      all_pass();
      run_sweep(0);
      @(posedge clk); force_bad[0] = 1'b1;
      repeat (8) @(posedge clk);
      force_bad[0] = 1'b0;
      dropped = 0;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (!done) begin dropped = 1; break; end
      end
      check("mon_drop", dropped, 1);
      check("mon_tap0", tap, 0);
      for (k = 1; k <= 800; k++) begin
        @(negedge clk);
        if (done) break;
      end
      check("mon_resweep", k, DONE_CYC - 1);
      check("mon_tap", tap, {NL{TW'(15)}});
      end_sweep();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
